// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand feeder.
//   SA_DATA_W / SA_N : default operand width and array dimension
//   sa_state_e       : feeder FSM states
//   lane_slice()     : extract one lane from a packed N-lane bus
package sa_pkg;

  localparam int unsigned SA_DATA_W = 64;
  localparam int unsigned SA_N      = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StStream = 3'd2,
    StFlush  = 3'd3,
    StDone   = 3'd4
  } sa_state_e;

  function automatic logic [SA_DATA_W-1:0] lane_slice(input logic [SA_N*SA_DATA_W-1:0] bus,
                                                      input int unsigned idx);
    return bus[idx*SA_DATA_W +: SA_DATA_W];
  endfunction

endpackage

// File: rtl/sa_skew_delay.sv
// DEPTH-stage register chain used to skew one operand lane.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   en_i   : shift enable (held low while the array is stalled)
//   clr_i  : synchronous clear of every stage
//   d_i    : lane input
//   q_o    : lane input delayed by DEPTH enabled cycles (DEPTH=0 passes through)
module sa_skew_delay #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i, clr_i};
    assign q_o = d_i;
  end else begin : g_chain
    logic [DEPTH-1:0][DATA_W-1:0] stage_q, stage_d;

    always_comb begin
      stage_d = stage_q;
      if (clr_i) begin
        stage_d = '0;
      end else if (en_i) begin
        stage_d[0] = d_i;
        for (int s = 1; s < DEPTH; s++) begin
          stage_d[s] = stage_q[s-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/sa_operand_feeder.sv
// Producer side of the NxN systolic-array operand interface.
// Buffers one K-deep tile (beat k = column k of A, row k of B), then streams the
// skewed a/b lanes into the array, flushes with zeros and pulses done.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : load handshake; in_last marks the final beat
//   in_a, in_b          : A[i][k] / B[k][j] packed per lane
//   stall               : freezes streaming/flushing
//   sa_a, sa_b          : skewed lane outputs to the array
//   sa_clear            : accumulator clear, first stream cycle
//   sa_active           : high during stream and flush
//   done                : one-cycle pulse when array results are final
module sa_operand_feeder
  import sa_pkg::*;
#(
  parameter int unsigned DATA_W = SA_DATA_W,
  parameter int unsigned N      = SA_N,
  parameter int unsigned K_MAX  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_a,
  input  logic [N*DATA_W-1:0] in_b,
  input  logic                in_last,
  input  logic                stall,
  output logic [N*DATA_W-1:0] sa_a,
  output logic [N*DATA_W-1:0] sa_b,
  output logic                sa_clear,
  output logic                sa_active,
  output logic                done
);

  localparam int unsigned CntW  = $clog2(K_MAX + 2 * N);
  localparam int unsigned IdxW  = $clog2(K_MAX);
  localparam int unsigned BeatW = 2 * N * DATA_W;

  sa_state_e       state_q, state_d;
  logic [CntW-1:0] k_q, k_d;  // beats in buffer, also the write pointer
  logic [CntW-1:0] t_q, t_d;  // un-stalled cycle count within STREAM, then within FLUSH

  logic [BeatW-1:0]    buf_q [K_MAX];
  logic [BeatW-1:0]    rd_entry;
  logic [N*DATA_W-1:0] src_a, src_b;
  logic                accept, streaming, advance;

  // in_ready is gated by rst_n so it is low during the reset cycle itself.
  assign in_ready  = rst_n && (state_q == StIdle || state_q == StLoad);
  assign accept    = in_valid && in_ready;
  assign streaming = (state_q == StStream);
  assign advance   = streaming && !stall;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          k_d = k_q + CntW'(1);
          t_d = '0;
          // The K_MAX-th beat is treated as last so the buffer can never overflow.
          if (in_last || k_q == CntW'(K_MAX - 1)) begin
            state_d = StStream;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StStream: begin
        if (!stall) begin
          if (t_q == k_q + CntW'(N - 2)) begin
            state_d = StFlush;
            t_d     = '0;
          end else begin
            t_d = t_q + CntW'(1);
          end
        end
      end
      StFlush: begin
        if (!stall) begin
          if (t_q == CntW'(N - 2)) begin
            state_d = StDone;
          end else begin
            t_d = t_q + CntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        k_d     = '0;
        t_d     = '0;
      end
      default: begin
        state_d = StIdle;
        k_d     = '0;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
    end
  end

  // Tile storage needs no reset: entries at or beyond k_q are never read.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[k_q[IdxW-1:0]] <= {in_b, in_a};
    end
  end

  assign rd_entry = buf_q[t_q[IdxW-1:0]];

  always_comb begin
    src_a = '0;
    src_b = '0;
    if (streaming && t_q < k_q) begin
      src_a = rd_entry[N*DATA_W-1:0];
      src_b = rd_entry[BeatW-1:N*DATA_W];
    end
  end

  // Lane i is delayed i cycles so the operands meet PE(i,j) on the same wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] a_skew, b_skew;

    sa_skew_delay #(
      .DATA_W(DATA_W),
      .DEPTH (i)
    ) u_skew_a (
      .clk_i (clk),
      .rst_ni(rst_n),
      .en_i  (advance),
      .clr_i (!streaming),
      .d_i   (lane_slice(src_a, i)),
      .q_o   (a_skew)
    );

    sa_skew_delay #(
      .DATA_W(DATA_W),
      .DEPTH (i)
    ) u_skew_b (
      .clk_i (clk),
      .rst_ni(rst_n),
      .en_i  (advance),
      .clr_i (!streaming),
      .d_i   (lane_slice(src_b, i)),
      .q_o   (b_skew)
    );

    assign sa_a[i*DATA_W +: DATA_W] = streaming ? a_skew : '0;
    assign sa_b[i*DATA_W +: DATA_W] = streaming ? b_skew : '0;
  end

  // Qualified by !stall so the clear lands on the cycle the array consumes t=0.
  assign sa_clear  = advance && (t_q == '0);
  assign sa_active = streaming || (state_q == StFlush);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_sa_operand_feeder.sv
module tb_sa_operand_feeder;
  localparam int DW = 64;
  localparam int N  = 4;
  localparam int KM = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*DW-1:0] in_a = '0;
  logic [N*DW-1:0] in_b = '0;
  logic          in_last = 1'b0;
  logic          stall = 1'b0;
  logic [N*DW-1:0] sa_a, sa_b;
  logic          sa_clear, sa_active, done;

  int total = 0;
  int bad   = 0;

  // Reference tile: A[i][k], B[k][j]
  logic [DW-1:0] ma [N][KM];
  logic [DW-1:0] mb [KM][N];
  // Lane values captured per un-stalled active cycle
  logic [DW-1:0] cap_a [64][N];
  logic [DW-1:0] cap_b [64][N];
  int last_lat;

  always #5 clk = ~clk;

  sa_operand_feeder #(
    .DATA_W(DW),
    .N     (N),
    .K_MAX (KM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .stall    (stall),
    .sa_a     (sa_a),
    .sa_b     (sa_b),
    .sa_clear (sa_clear),
    .sa_active(sa_active),
    .done     (done)
  );

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        ma[i][kk] = 64'($urandom_range(0, 65535));
        mb[kk][i] = 64'($urandom_range(0, 65535));
      end
    end
  endtask

  task automatic load_tile(input int k, input bit use_last);
    for (int b = 0; b < k; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        in_a[i*DW +: DW] = ma[i][b];
        in_b[i*DW +: DW] = mb[b][i];
      end
      in_last = use_last && (b == k - 1);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_ready beat=%0d got=%b exp=1", b, in_ready);
      end
    end
  endtask

  // Streams one loaded tile, checking every lane against the skew rule, then
  // multiplies the captured streams as an ideal array would and compares to A*B.
  task automatic stream_check(input int k, input int stall_at, input int stall_len,
                              input string name);
    int u, n, stalled, done_n, big_u;
    bit fin;
    logic [DW-1:0] e, y, r;
    u = 0; n = 0; stalled = 0; done_n = -1; fin = 1'b0;
    big_u = k + 2 * N - 2;
    while (!fin && n < 200) begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      in_last  = 1'b0;
      stall    = (u == stall_at) && (stalled < stall_len);
      #1;
      for (int i = 0; i < N; i++) begin
        e = (u >= i && u - i < k) ? ma[i][u-i] : '0;
        total++;
        if (sa_a[i*DW +: DW] !== e) begin
          bad++;
          $display("FAIL %s sa_a lane%0d t=%0d got=%h exp=%h", name, i, u, sa_a[i*DW +: DW], e);
        end
        e = (u >= i && u - i < k) ? mb[u-i][i] : '0;
        total++;
        if (sa_b[i*DW +: DW] !== e) begin
          bad++;
          $display("FAIL %s sa_b lane%0d t=%0d got=%h exp=%h", name, i, u, sa_b[i*DW +: DW], e);
        end
      end
      total++;
      if (sa_active !== (u < big_u)) begin
        bad++;
        $display("FAIL %s sa_active cyc=%0d got=%b exp=%b", name, n, sa_active, u < big_u);
      end
      total++;
      if (sa_clear !== (n == 1)) begin
        bad++;
        $display("FAIL %s sa_clear cyc=%0d got=%b exp=%b", name, n, sa_clear, n == 1);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s in_ready_busy cyc=%0d got=%b exp=0", name, n, in_ready);
      end
      if (done === 1'b1) begin
        done_n = n;
        fin = 1'b1;
      end else if (u < big_u) begin
        if (stall) begin
          stalled++;
        end else begin
          for (int i = 0; i < N; i++) begin
            cap_a[u][i] = sa_a[i*DW +: DW];
            cap_b[u][i] = sa_b[i*DW +: DW];
          end
          u++;
        end
      end
    end
    stall = 1'b0;
    last_lat = done_n;
    total++;
    if (done_n != big_u + 1 + stall_len) begin
      bad++;
      $display("FAIL %s done_latency got=%0d exp=%0d", name, done_n, big_u + 1 + stall_len);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        y = '0;
        r = '0;
        for (int t = 0; t < u; t++) begin
          if (t >= i && t >= j) y += cap_a[t-j][i] * cap_b[t-i][j];
        end
        for (int kk = 0; kk < k; kk++) r += ma[i][kk] * mb[kk][j];
        total++;
        if (y !== r) begin
          bad++;
          $display("FAIL %s y[%0d][%0d] got=%h exp=%h", name, i, j, y, r);
        end
      end
    end
  endtask

  task automatic test_reset();
    fill_random(4);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0 || sa_active !== 1'b0 || done !== 1'b0 || sa_clear !== 1'b0 ||
          sa_a !== '0 || sa_b !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%b%b%b%b exp=0000", c, in_ready, sa_active,
                 done, sa_clear);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
    // Reset in the middle of a load discards the partial tile.
    load_tile(2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midload_reset_ready got=%b exp=0", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midload_release_ready got=%b exp=1", in_ready);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (done !== 1'b0 || sa_active !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_quiet cyc=%0d got=%b%b exp=00", c, done, sa_active);
      end
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++) begin
      for (int kk = 0; kk < 4; kk++) begin
        ma[i][kk] = (i == kk) ? 64'd1 : 64'd0;
        mb[kk][i] = (i == kk) ? 64'd1 : 64'd0;
      end
    end
    load_tile(4, 1'b1);
    stream_check(4, -1, 0, "identity");
    total++;
    if (last_lat != 11) begin
      bad++;
      $display("FAIL identity_done_at_11 got=%0d exp=11", last_lat);
    end
  endtask

  task automatic test_k1();
    for (int i = 0; i < N; i++) begin
      ma[i][0] = 64'(i + 1);
      mb[0][i] = 64'(i + 5);
    end
    load_tile(1, 1'b1);
    stream_check(1, -1, 0, "k1");
    total++;
    if (last_lat != 8) begin
      bad++;
      $display("FAIL k1_done_at_8 got=%0d exp=8", last_lat);
    end
  endtask

  task automatic test_kmax_overflow();
    fill_random(KM);
    load_tile(KM, 1'b0);
    stream_check(KM, -1, 0, "kmax");
    total++;
    if (last_lat != KM + 2 * N - 1) begin
      bad++;
      $display("FAIL kmax_done_latency got=%0d exp=%0d", last_lat, KM + 2 * N - 1);
    end
  endtask

  task automatic test_stall();
    fill_random(4);
    load_tile(4, 1'b1);
    stream_check(4, 2, 3, "stall");
    total++;
    if (last_lat != 14) begin
      bad++;
      $display("FAIL stall_done_delayed got=%0d exp=14", last_lat);
    end
  endtask

  task automatic test_random_tiles();
    int k;
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, KM);
      fill_random(k);
      load_tile(k, 1'b1);
      stream_check(k, $urandom_range(0, 1) ? int'($urandom_range(0, k + 4)) : -1,
                   $urandom_range(1, 4), "random");
    end
  endtask

  // K=1 tiles with in_valid/in_last held high: one tile every 1+(1+N-1)+(N-1)+1 cycles.
  task automatic test_back_to_back();
    int period;
    period = 2 * N + 1;
    for (int n = 1; n <= 2 * period; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #1;
      total++;
      if (in_ready !== (n % period == 1)) begin
        bad++;
        $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", n, in_ready, n % period == 1);
      end
      total++;
      if (sa_clear !== (n % period == 2)) begin
        bad++;
        $display("FAIL b2b_sa_clear cyc=%0d got=%b exp=%b", n, sa_clear, n % period == 2);
      end
      total++;
      if (done !== (n % period == 0)) begin
        bad++;
        $display("FAIL b2b_done cyc=%0d got=%b exp=%b", n, done, n % period == 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_k1();
    test_kmax_overflow();
    test_stall();
    test_random_tiles();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
